// File: rtl/sched_ctrl_pkg.sv
// sched_ctrl_pkg: shared definitions for the schedule controller.
//   - FSM state encoding (IDLE, S1..S5)
//   - operand select codes and unit opcodes driven to the datapath
//   - ctrl_word_t: the full control word for one schedule step
package sched_ctrl_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0] SEL_I1   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_I2   = 4'd1;
    localparam logic [SEL_W-1:0] SEL_I3   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_ALU0 = 4'd3;
    localparam logic [SEL_W-1:0] SEL_MUL1 = 4'd4;
    localparam logic [SEL_W-1:0] SEL_MUL2 = 4'd5;
    localparam logic [SEL_W-1:0] SEL_LOG3 = 4'd6;
    localparam logic [SEL_W-1:0] SEL_MUL4 = 4'd7;
    localparam logic [SEL_W-1:0] SEL_ALU5 = 4'd8;
    // Unused-unit code; the datapath mux default returns 0 for it.
    localparam logic [SEL_W-1:0] SEL_IDLE = 4'd15;

    localparam logic       ALU_ADD = 1'b0;
    localparam logic       ALU_SUB = 1'b1;
    localparam logic [1:0] LOG_AND = 2'b00;
    localparam logic [1:0] LOG_OR  = 2'b01;
    localparam logic [1:0] LOG_XOR = 2'b10;
    localparam logic       MUL_MUL = 1'b0;
    localparam logic       MUL_DIV = 1'b1;

    typedef struct packed {
        logic [SEL_W-1:0] alu1_sel1;
        logic [SEL_W-1:0] alu1_sel2;
        logic [SEL_W-1:0] log1_sel1;
        logic [SEL_W-1:0] log1_sel2;
        logic [SEL_W-1:0] mul1_sel1;
        logic [SEL_W-1:0] mul1_sel2;
        logic             alu1_op;
        logic [1:0]       log1_op;
        logic             mul1_op;
        logic             reg_alu0_en;
        logic             reg_alu5_en;
        logic             reg_log3_en;
        logic             reg_mul1_en;
        logic             reg_mul2_en;
        logic             reg_mul4_en;
        logic             result_en;
        logic             done_next;
    } ctrl_word_t;

    localparam int CW_W = $bits(ctrl_word_t);

    // Control word with every unit parked and nothing loading.
    function automatic ctrl_word_t cw_idle();
        ctrl_word_t w;
        w           = '0;
        w.alu1_sel1 = SEL_IDLE;
        w.alu1_sel2 = SEL_IDLE;
        w.log1_sel1 = SEL_IDLE;
        w.log1_sel2 = SEL_IDLE;
        w.mul1_sel1 = SEL_IDLE;
        w.mul1_sel2 = SEL_IDLE;
        return w;
    endfunction

endpackage

// File: rtl/sched_ctrl_if.sv
// sched_ctrl_if: handshake plus datapath control bundle.
//   master : requester/datapath side (drives start/stall, consumes controls)
//   slave  : controller side (sched_ctrl)
interface sched_ctrl_if;
    import sched_ctrl_pkg::*;

    logic             start;
    logic             stall;
    logic             ready;
    logic             busy;
    logic [SEL_W-1:0] alu1_sel1, alu1_sel2;
    logic [SEL_W-1:0] log1_sel1, log1_sel2;
    logic [SEL_W-1:0] mul1_sel1, mul1_sel2;
    logic             alu1_op;
    logic [1:0]       log1_op;
    logic             mul1_op;
    logic             reg_alu0_en, reg_alu5_en, reg_log3_en;
    logic             reg_mul1_en, reg_mul2_en, reg_mul4_en;
    logic             result_en;
    logic             done_next;

    modport slave (
        input  start, stall,
        output ready, busy,
        output alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2,
        output alu1_op, log1_op, mul1_op,
        output reg_alu0_en, reg_alu5_en, reg_log3_en,
        output reg_mul1_en, reg_mul2_en, reg_mul4_en,
        output result_en, done_next
    );

    modport master (
        output start, stall,
        input  ready, busy,
        input  alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2,
        input  alu1_op, log1_op, mul1_op,
        input  reg_alu0_en, reg_alu5_en, reg_log3_en,
        input  reg_mul1_en, reg_mul2_en, reg_mul4_en,
        input  result_en, done_next
    );

endinterface

// File: rtl/sched_step_decode.sv
// sched_step_decode: combinational state -> control word lookup.
//   state_i : current schedule state
//   cw_o    : ungated control word for that step
module sched_step_decode
    import sched_ctrl_pkg::*;
(
    input  state_t     state_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o = cw_idle();
        case (state_i)
            ST_S1: begin    // i1+i2 -> alu0 ; i2*i3 -> mul1
                cw_o.alu1_sel1   = SEL_I1;
                cw_o.alu1_sel2   = SEL_I2;
                cw_o.alu1_op     = ALU_ADD;
                cw_o.mul1_sel1   = SEL_I2;
                cw_o.mul1_sel2   = SEL_I3;
                cw_o.mul1_op     = MUL_MUL;
                cw_o.reg_alu0_en = 1'b1;
                cw_o.reg_mul1_en = 1'b1;
            end
            ST_S2: begin    // alu0*i1 -> mul2 ; mul1^i3 -> log3
                cw_o.mul1_sel1   = SEL_ALU0;
                cw_o.mul1_sel2   = SEL_I1;
                cw_o.mul1_op     = MUL_MUL;
                cw_o.log1_sel1   = SEL_MUL1;
                cw_o.log1_sel2   = SEL_I3;
                cw_o.log1_op     = LOG_XOR;
                cw_o.reg_mul2_en = 1'b1;
                cw_o.reg_log3_en = 1'b1;
            end
            ST_S3: begin    // mul2*log3 -> mul4
                cw_o.mul1_sel1   = SEL_MUL2;
                cw_o.mul1_sel2   = SEL_LOG3;
                cw_o.mul1_op     = MUL_MUL;
                cw_o.reg_mul4_en = 1'b1;
            end
            ST_S4: begin    // mul4-alu0 -> alu5
                cw_o.alu1_sel1   = SEL_MUL4;
                cw_o.alu1_sel2   = SEL_ALU0;
                cw_o.alu1_op     = ALU_SUB;
                cw_o.reg_alu5_en = 1'b1;
            end
            ST_S5: begin    // alu5+log3 -> result, raise done
                cw_o.alu1_sel1   = SEL_ALU5;
                cw_o.alu1_sel2   = SEL_LOG3;
                cw_o.alu1_op     = ALU_ADD;
                cw_o.result_en   = 1'b1;
                cw_o.done_next   = 1'b1;
            end
            default: cw_o = cw_idle();
        endcase
    end

endmodule

// File: rtl/sched_ctrl.sv
// sched_ctrl: 5-step schedule FSM for the shared ALU/MUL/LOG datapath.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of sched_ctrl_if (start/stall in, ready/busy and
//              all datapath selects, opcodes and load enables out)
module sched_ctrl
    import sched_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    sched_ctrl_if.slave  bus
);

    state_t     state_q, state_d;
    ctrl_word_t cw_raw, cw;

    sched_step_decode u_dec (
        .state_i (state_q),
        .cw_o    (cw_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_S1;
            ST_S1:   if (!bus.stall) state_d = ST_S2;
            ST_S2:   if (!bus.stall) state_d = ST_S3;
            ST_S3:   if (!bus.stall) state_d = ST_S4;
            ST_S4:   if (!bus.stall) state_d = ST_S5;
            ST_S5:   if (!bus.stall) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall keeps the operand routing stable but blocks every load, so the
    // step simply re-executes once stall drops.
    always_comb begin
        cw = cw_raw;
        if (bus.stall) begin
            cw.reg_alu0_en = 1'b0;
            cw.reg_alu5_en = 1'b0;
            cw.reg_log3_en = 1'b0;
            cw.reg_mul1_en = 1'b0;
            cw.reg_mul2_en = 1'b0;
            cw.reg_mul4_en = 1'b0;
            cw.result_en   = 1'b0;
            cw.done_next   = 1'b0;
        end
    end

    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.alu1_sel1   = cw.alu1_sel1;
    assign bus.alu1_sel2   = cw.alu1_sel2;
    assign bus.log1_sel1   = cw.log1_sel1;
    assign bus.log1_sel2   = cw.log1_sel2;
    assign bus.mul1_sel1   = cw.mul1_sel1;
    assign bus.mul1_sel2   = cw.mul1_sel2;
    assign bus.alu1_op     = cw.alu1_op;
    assign bus.log1_op     = cw.log1_op;
    assign bus.mul1_op     = cw.mul1_op;
    assign bus.reg_alu0_en = cw.reg_alu0_en;
    assign bus.reg_alu5_en = cw.reg_alu5_en;
    assign bus.reg_log3_en = cw.reg_log3_en;
    assign bus.reg_mul1_en = cw.reg_mul1_en;
    assign bus.reg_mul2_en = cw.reg_mul2_en;
    assign bus.reg_mul4_en = cw.reg_mul4_en;
    assign bus.result_en   = cw.result_en;
    assign bus.done_next   = cw.done_next;

endmodule

// File: tb/tb_sched_ctrl.sv
// tb_sched_ctrl: controller with a behavioural datapath attached. Stimulus
// pushes expected results into a scoreboard; a monitor pops on every done.
module tb_sched_ctrl;
    import sched_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sched_ctrl_if bus();
    sched_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // ---------------- behavioural datapath ----------------
    logic [31:0] i1, i2, i3;
    logic [31:0] r_alu0, r_mul1, r_mul2, r_log3, r_mul4, r_alu5, result_q;
    logic        done_q;
    logic [31:0] alu_y, log_y, mul_y, a1, a2, l1, l2, m1, m2;

    function automatic logic [31:0] pick(input logic [3:0] s);
        case (s)
            4'd0: return i1;
            4'd1: return i2;
            4'd2: return i3;
            4'd3: return r_alu0;
            4'd4: return r_mul1;
            4'd5: return r_mul2;
            4'd6: return r_log3;
            4'd7: return r_mul4;
            4'd8: return r_alu5;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        a1 = pick(bus.alu1_sel1); a2 = pick(bus.alu1_sel2);
        l1 = pick(bus.log1_sel1); l2 = pick(bus.log1_sel2);
        m1 = pick(bus.mul1_sel1); m2 = pick(bus.mul1_sel2);
        alu_y = bus.alu1_op ? a1 - a2 : a1 + a2;
        case (bus.log1_op)
            2'b00:   log_y = l1 & l2;
            2'b01:   log_y = l1 | l2;
            2'b10:   log_y = l1 ^ l2;
            default: log_y = 32'd0;
        endcase
        if (bus.mul1_op) mul_y = (m2 == 0) ? 32'd0 : m1 / m2;
        else             mul_y = m1 * m2;
    end

    always @(posedge clk) begin
        if (bus.reg_alu0_en) r_alu0 <= alu_y;
        if (bus.reg_alu5_en) r_alu5 <= alu_y;
        if (bus.reg_log3_en) r_log3 <= log_y;
        if (bus.reg_mul1_en) r_mul1 <= mul_y;
        if (bus.reg_mul2_en) r_mul2 <= mul_y;
        if (bus.reg_mul4_en) r_mul4 <= mul_y;
        if (bus.result_en)   result_q <= alu_y;
        done_q <= rst ? 1'b0 : bus.done_next;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] alu0, mul1, mul2, log3, mul4, alu5, res;
        int          t;
    } exp_t;
    exp_t sb[$];

    int n_mul4 = 0;
    int n_res  = 0;

    always @(negedge clk) begin
        if (bus.reg_mul4_en) n_mul4++;
        if (bus.result_en)   n_res++;
        if (done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.t));
                chk("reg_alu0", 64'(r_alu0), 64'(e.alu0));
                chk("reg_mul1", 64'(r_mul1), 64'(e.mul1));
                chk("reg_mul2", 64'(r_mul2), 64'(e.mul2));
                chk("reg_log3", 64'(r_log3), 64'(e.log3));
                chk("reg_mul4", 64'(r_mul4), 64'(e.mul4));
                chk("reg_alu5", 64'(r_alu5), 64'(e.alu5));
                chk("result", 64'(result_q), 64'(e.res));
            end
        end
    end

    // Hand-written schedule table with literal select codes.
    function automatic ctrl_word_t exp_word(input int k, input bit stalled);
        ctrl_word_t w;
        w = '0;
        w.alu1_sel1 = 4'd15; w.alu1_sel2 = 4'd15;
        w.log1_sel1 = 4'd15; w.log1_sel2 = 4'd15;
        w.mul1_sel1 = 4'd15; w.mul1_sel2 = 4'd15;
        case (k)
            1: begin w.alu1_sel1 = 4'd0; w.alu1_sel2 = 4'd1;
                     w.mul1_sel1 = 4'd1; w.mul1_sel2 = 4'd2;
                     w.reg_alu0_en = !stalled; w.reg_mul1_en = !stalled; end
            2: begin w.mul1_sel1 = 4'd3; w.mul1_sel2 = 4'd0;
                     w.log1_sel1 = 4'd4; w.log1_sel2 = 4'd2; w.log1_op = 2'b10;
                     w.reg_mul2_en = !stalled; w.reg_log3_en = !stalled; end
            3: begin w.mul1_sel1 = 4'd5; w.mul1_sel2 = 4'd6;
                     w.reg_mul4_en = !stalled; end
            4: begin w.alu1_sel1 = 4'd7; w.alu1_sel2 = 4'd3; w.alu1_op = 1'b1;
                     w.reg_alu5_en = !stalled; end
            5: begin w.alu1_sel1 = 4'd8; w.alu1_sel2 = 4'd6;
                     w.result_en = !stalled; w.done_next = !stalled; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic ctrl_word_t dut_word();
        ctrl_word_t w;
        w.alu1_sel1 = bus.alu1_sel1;  w.alu1_sel2 = bus.alu1_sel2;
        w.log1_sel1 = bus.log1_sel1;  w.log1_sel2 = bus.log1_sel2;
        w.mul1_sel1 = bus.mul1_sel1;  w.mul1_sel2 = bus.mul1_sel2;
        w.alu1_op = bus.alu1_op; w.log1_op = bus.log1_op; w.mul1_op = bus.mul1_op;
        w.reg_alu0_en = bus.reg_alu0_en; w.reg_alu5_en = bus.reg_alu5_en;
        w.reg_log3_en = bus.reg_log3_en; w.reg_mul1_en = bus.reg_mul1_en;
        w.reg_mul2_en = bus.reg_mul2_en; w.reg_mul4_en = bus.reg_mul4_en;
        w.result_en = bus.result_en; w.done_next = bus.done_next;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    exp_t nom, wrp;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Assumes we sit #1 after a posedge with the DUT in IDLE. Returns #1
    // after the accepting edge E0, with the expected result queued.
    task automatic issue(input exp_t e, input int stalls);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e.t = cyc + 5 + stalls;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin tick(); n++; end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int m0, r0;
        bus.start = 1'b0; bus.stall = 1'b0;
        i1 = 32'd3; i2 = 32'd5; i3 = 32'd6;
        nom = '{alu0:8, mul1:30, mul2:24, log3:24, mul4:576, alu5:568, res:592, t:0};
        wrp = '{alu0:0, mul1:2, mul2:0, log3:0, mul4:0, alu5:0, res:0, t:0};

        // reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_word", 64'(dut_word()), 64'(exp_word(0, 0)));
        rst = 1'b0;
        tick();

        // nominal run with per-state control word check
        issue(nom, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("word_s%0d", k), 64'(dut_word()), 64'(exp_word(k, 0)));
            chk($sformatf("busy_s%0d", k), 64'({bus.busy, bus.ready}), 64'b10);
            tick();
        end
        @(negedge clk);
        chk("ready_after_run", 64'(bus.ready), 64'd1);
        chk("idle_word", 64'(dut_word()), 64'(exp_word(0, 0)));
        tick();
        drain(10);

        // stall for 2 cycles in S3
        m0 = n_mul4;
        issue(nom, 2);
        tick(); tick();                     // now in S3
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_word", 64'(dut_word()), 64'(exp_word(3, 1)));
            tick();
        end
        bus.stall = 1'b0;
        drain(20);
        chk("mul4_loads", 64'(n_mul4 - m0), 64'd1);

        // start held high: back-to-back runs 6 cycles apart
        bus.start = 1'b1;
        tick();
        nom.t = cyc + 5;  sb.push_back(nom);
        nom.t = cyc + 11; sb.push_back(nom);
        repeat (6) tick();
        bus.start = 1'b0;
        drain(20);

        // start pulse during S2 is ignored
        issue(nom, 0);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drain(20);
        repeat (8) tick();
        chk("s2_start_ignored", 64'({bus.ready, bus.busy}), 64'b10);

        // reset in S4
        r0 = n_res;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();                  // now in S4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'({bus.ready, bus.busy}), 64'b10);
        chk("rst_mid_word", 64'(dut_word()), 64'(exp_word(0, 0)));
        repeat (10) tick();
        chk("rst_mid_no_result_en", 64'(n_res - r0), 64'd0);
        chk("rst_mid_done", 64'(done_q), 64'd0);

        // 32-bit wraparound
        i1 = 32'hFFFF_FFFF; i2 = 32'd1; i3 = 32'd2;
        issue(wrp, 0);
        drain(10);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sched_ctrl.md
Name: sched_ctrl

Overview:
- FSM controller that sequences the shared datapath (one ALU, one MUL/DIV, one LOG unit, six intermediate registers, a result register and a done register) through a fixed 5-step schedule.
- Drives every operand-select, opcode, register-enable, result_en and done_next line of the datapath.
- Accepts a start handshake and supports a stall input that freezes the schedule.

Parameters:
- SEL_W, 4, width of every operand-select output.
- SEL_IDLE, 4'd15, select code driven when a unit is unused (datapath mux default yields 0).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a computation; sampled only in IDLE
- stall  in  1  freeze current step; all enables forced 0 while high
- ready  out  1  high in IDLE (start will be accepted)
- busy  out  1  high in S1..S5
- alu1_sel1, alu1_sel2, log1_sel1, log1_sel2, mul1_sel1, mul1_sel2  out  SEL_W each  operand selects
- alu1_op  out  1  0 add, 1 sub
- log1_op  out  2  00 and, 01 or, 10 xor
- mul1_op  out  1  0 mul, 1 div
- reg_alu0_en, reg_alu5_en, reg_log3_en, reg_mul1_en, reg_mul2_en, reg_mul4_en  out  1 each  register load enables
- result_en  out  1  load result from ALU
- done_next  out  1  datapath registers it into done

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high; clk and rst are the only timing inputs.
- Select codes: 0 i1, 1 i2, 2 i3, 3 reg_alu0, 4 reg_mul1, 5 reg_mul2, 6 reg_log3, 7 reg_mul4, 8 reg_alu5.
- States: IDLE, S1..S5 (registered state, one-hot or binary; the choice is free).
- Outputs are a combinational (Moore) decode of the state, gated by stall for the enables.
- Schedule:
  - S1: ALU i1+i2 -> reg_alu0; MUL i2*i3 -> reg_mul1.
  - S2: MUL reg_alu0*i1 -> reg_mul2; LOG reg_mul1^i3 -> reg_log3.
  - S3: MUL reg_mul2*reg_log3 -> reg_mul4.
  - S4: ALU reg_mul4-reg_alu0 -> reg_alu5.
  - S5: ALU reg_alu5+reg_log3 -> result; result_en=1, done_next=1.
- Unused units in a step: selects = SEL_IDLE, op = 0.
- In IDLE: all selects SEL_IDLE, all ops 0, all enables/result_en/done_next 0.
- Transitions:
  - IDLE -> S1 when start.
  - Sk -> Sk+1 when !stall; Sk holds when stall.
  - S5 -> IDLE when !stall.
- start outside IDLE is ignored (no queuing).
- Stall: selects/ops keep the current step's values; all *_en, result_en and done_next are 0; the state holds.
- Latency: start sampled at edge E0; S1..S5 occupy cycles after edges E0..E4; result and done update at E5. The datapath done pulse is exactly 1 cycle per run with no stall, plus N cycles of latency for N stalled cycles.
- Back-to-back: next start is accepted the cycle after S5 (IDLE); minimum period is 6 cycles.
- rst mid-run: the next edge forces IDLE and all outputs go to their idle values. No partial done_next may be emitted.
- Reset values: ready=1, busy=0, all enables/result_en/done_next=0, selects=SEL_IDLE, ops=0.

Decomposition:
- Shared package holds:
  - state encoding;
  - select code constants (SEL_I1..SEL_ALU5, SEL_IDLE);
  - ALU/LOG/MUL opcode constants;
  - control-word struct/width.
- One sub-module, sched_step_decode: purely combinational state -> control-word lookup. sched_ctrl holds the FSM, stall gating and handshake.

Test Plan:
- Nominal run, datapath attached, i1=3, i2=5, i3=6, start 1 cycle:
  - intermediates: reg_alu0=8, reg_mul1=30, reg_mul2=24, reg_log3=24, reg_mul4=576, reg_alu5=568;
  - result=592;
  - done high exactly 1 cycle, 5 edges after the start edge; ready returns high the same cycle.
- Stall 2 cycles in S3 with the same inputs: reg_mul4 is loaded once only, result=592, done delayed by 2 cycles, no enable pulses during the stall.
- start held high through a whole run: a second run starts immediately after IDLE, giving done pulses 6 cycles apart. A start pulse in S2 alone is ignored.
- rst asserted in S4: the next edge shows IDLE, busy=0, result_en/done_next never asserted, and the datapath done stays 0.
- Output check per state: every select/op/enable matches the schedule table. Unused selects read 15 and the IDLE control word is all idle values.
- i1=0xFFFFFFFF, i2=1, i3=2: reg_alu0 wraps to 0, reg_mul1=2, reg_mul2=0, reg_log3=0, reg_mul4=0, reg_alu5=0, result=0 (32-bit modular arithmetic).
